// File: rtl/m_pool_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// m_pool_buf_ctrl_if
// Handshake and buffer-address bundle between the ping-pong pool buffer
// sequencer and its neighbours (conv-layer writer, relu/pool reader, frame
// control).
//
// Signals:
//   start        frame start pulse (into controller)
//   busy         frame in progress
//   conv_valid   conv layer offers a pixel (into controller)
//   conv_ready   controller accepts the pixel
//   buf_wr_en    buffer write enable
//   buf_wr_addr  buffer write address (7 bits)
//   pool_ready   pooling layer can take data next cycle (into controller)
//   buf_rd_en    buffer read enable
//   buf_rd_addr  buffer read address (7 bits)
//   rd_valid     buffer read data valid this cycle
//   rd_pos       2x2 window position of the current read data
//   win_last     last pixel of a window is on the read data
//   frame_done   final read data of the frame
//
// Modports:
//   master  the sequencer (m_pool_buf_ctrl)
//   slave   the surrounding datapath / testbench
// ---------------------------------------------------------------------------
interface m_pool_buf_ctrl_if;
  logic       start;
  logic       busy;
  logic       conv_valid;
  logic       conv_ready;
  logic       buf_wr_en;
  logic [6:0] buf_wr_addr;
  logic       pool_ready;
  logic       buf_rd_en;
  logic [6:0] buf_rd_addr;
  logic       rd_valid;
  logic [1:0] rd_pos;
  logic       win_last;
  logic       frame_done;

  modport master (
    input  start, conv_valid, pool_ready,
    output busy, conv_ready, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, rd_valid, rd_pos, win_last, frame_done
  );

  modport slave (
    output start, conv_valid, pool_ready,
    input  busy, conv_ready, buf_wr_en, buf_wr_addr,
           buf_rd_en, buf_rd_addr, rd_valid, rd_pos, win_last, frame_done
  );
endinterface

// File: rtl/m_pool_buf_ctrl.sv
// ---------------------------------------------------------------------------
// m_pool_buf_ctrl
// Sequencer for the 4 x COLS ping-pong buffer between the first conv layer
// and the relu/pooling layer. The buffer is split into two halves of two rows
// each. The writer fills one half row-major while the reader drains the other
// half in 2x2 windows (TL, TR, BL, BR). A half is only read once it is FULL
// and only written while it is not FULL, so the two sides never collide.
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   m_pool_buf_ctrl_if.master (handshakes, buffer addresses, status)
// ---------------------------------------------------------------------------
module m_pool_buf_ctrl #(
  parameter int COLS      = 26,
  parameter int ROWS      = 26,
  parameter int HALF_SIZE = 2 * COLS
) (
  input logic             clk,
  input logic             rst,
  m_pool_buf_ctrl_if.master bus
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} half_state_t;

  localparam logic [6:0] COLS_A    = 7'(COLS);
  localparam logic [6:0] HALF_A    = 7'(HALF_SIZE);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [6:0] WIN_LAST  = 7'(COLS / 2 - 1);
  localparam logic [6:0] PAIR_LAST = 7'(ROWS / 2 - 1);

  half_state_t half_st [2];

  logic       busy_q;
  logic       frame_done_q;
  logic       rd_valid_q;
  logic [1:0] rd_pos_q;

  logic       wr_half;
  logic       wr_row;
  logic [6:0] wr_col;
  logic [6:0] wr_pair;
  logic       wr_done;

  logic       rd_half;
  logic [6:0] rd_win;
  logic [1:0] iss_pos;
  logic [6:0] rd_pair;

  logic conv_ready_c;
  logic wr_fire;
  logic rd_fire;
  logic wr_half_last;
  logic rd_half_last;
  logic rd_frame_last;
  logic start_ok;

  // Handshake decode. frame_done blocks start because busy has already
  // dropped in that cycle but the frame is not considered over until after it.
  assign conv_ready_c  = busy_q && (half_st[wr_half] != FULL) && !wr_done;
  assign wr_fire       = bus.conv_valid && conv_ready_c;
  assign rd_fire       = busy_q && (half_st[rd_half] == FULL) && bus.pool_ready;
  assign wr_half_last  = wr_row && (wr_col == COL_LAST);
  assign rd_half_last  = (iss_pos == 2'd3) && (rd_win == WIN_LAST);
  assign rd_frame_last = rd_half_last && (rd_pair == PAIR_LAST);
  assign start_ok      = bus.start && !busy_q && !frame_done_q;

  // Address generation: half base + row offset + column. The read column is
  // 2*window plus the right-hand bit of the window position.
  assign bus.buf_wr_addr = (wr_half ? HALF_A : 7'd0) + (wr_row ? COLS_A : 7'd0) + wr_col;
  assign bus.buf_rd_addr = (rd_half ? HALF_A : 7'd0) + (iss_pos[1] ? COLS_A : 7'd0)
                         + {rd_win[5:0], 1'b0} + {6'd0, iss_pos[0]};

  assign bus.busy       = busy_q;
  assign bus.conv_ready = conv_ready_c;
  assign bus.buf_wr_en  = wr_fire;
  assign bus.buf_rd_en  = rd_fire;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_pos     = rd_pos_q;
  assign bus.win_last   = rd_valid_q && (rd_pos_q == 2'd3);
  assign bus.frame_done = frame_done_q;

  // Main sequencer. Writer and reader always act on different halves (the
  // writer never targets a FULL half, the reader only reads a FULL one), so
  // their half-status updates in the same cycle never touch the same entry.
  // The read pipeline registers (rd_valid/rd_pos/frame_done) mirror the
  // buffer's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_st[0]   <= EMPTY;
      half_st[1]   <= EMPTY;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_pos_q     <= 2'd0;
      wr_half      <= 1'b0;
      wr_row       <= 1'b0;
      wr_col       <= 7'd0;
      wr_pair      <= 7'd0;
      wr_done      <= 1'b0;
      rd_half      <= 1'b0;
      rd_win       <= 7'd0;
      iss_pos      <= 2'd0;
      rd_pair      <= 7'd0;
    end else begin
      frame_done_q <= rd_fire && rd_frame_last;
      rd_valid_q   <= rd_fire;
      if (rd_fire) begin
        rd_pos_q <= iss_pos;
      end

      if (start_ok) begin
        busy_q     <= 1'b1;
        half_st[0] <= EMPTY;
        half_st[1] <= EMPTY;
        wr_half    <= 1'b0;
        wr_row     <= 1'b0;
        wr_col     <= 7'd0;
        wr_pair    <= 7'd0;
        wr_done    <= 1'b0;
        rd_half    <= 1'b0;
        rd_win     <= 7'd0;
        iss_pos    <= 2'd0;
        rd_pair    <= 7'd0;
      end else begin
        if (wr_fire) begin
          if (wr_half_last) begin
            half_st[wr_half] <= FULL;
            wr_half          <= ~wr_half;
            wr_row           <= 1'b0;
            wr_col           <= 7'd0;
            if (wr_pair == PAIR_LAST) begin
              wr_done <= 1'b1;
            end else begin
              wr_pair <= wr_pair + 7'd1;
            end
          end else begin
            half_st[wr_half] <= FILLING;
            if (wr_col == COL_LAST) begin
              wr_col <= 7'd0;
              wr_row <= 1'b1;
            end else begin
              wr_col <= wr_col + 7'd1;
            end
          end
        end

        if (rd_fire) begin
          iss_pos <= iss_pos + 2'd1;
          if (iss_pos == 2'd3) begin
            if (rd_half_last) begin
              half_st[rd_half] <= EMPTY;
              rd_half          <= ~rd_half;
              rd_win           <= 7'd0;
              if (rd_frame_last) begin
                busy_q <= 1'b0;
              end else begin
                rd_pair <= rd_pair + 7'd1;
              end
            end else begin
              rd_win <= rd_win + 7'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_m_pool_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m_pool_buf_ctrl
// Directed self-checking bench for the ping-pong pool buffer sequencer.
// Write address k of a frame is k mod 104; read k belongs to window k/4 at
// position k mod 4, in half (window/13) mod 2, column 2*(window mod 13).
// ---------------------------------------------------------------------------
module tb_m_pool_buf_ctrl;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  m_pool_buf_ctrl_if bus ();

  m_pool_buf_ctrl #(.COLS(26), .ROWS(26), .HALF_SIZE(52)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected buffer address of read number k within a frame.
  function automatic logic [6:0] exp_rd_addr(input int k);
    int w;
    int p;
    w = k / 4;
    p = k % 4;
    return 7'(((w / 13) % 2) * 52 + (p / 2) * 26 + 2 * (w % 13) + (p % 2));
  endfunction

  // Reset values while reset is held, and conv_ready low while idle.
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.conv_valid = 1'b1;
    bus.pool_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.busy, bus.conv_ready, bus.buf_wr_en, bus.buf_rd_en, bus.rd_valid,
         bus.frame_done, bus.win_last} !== 7'b0) begin
      $display("[TB] FAIL reset_outputs: got %b required 0000000",
               {bus.busy, bus.conv_ready, bus.buf_wr_en, bus.buf_rd_en,
                bus.rd_valid, bus.frame_done, bus.win_last});
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({bus.busy, bus.conv_ready} !== 2'b00) begin
      $display("[TB] FAIL idle_no_ready: got busy/conv_ready %b required 00",
               {bus.busy, bus.conv_ready});
    end else passed++;
  endtask

  // First two windows read 0,1,26,27 / 2,3,28,29 and half 1 starts at 52.
  task automatic test_first_window();
    int   exp_a [8];
    int   rd_cnt;
    logic prev_en;
    logic [1:0] prev_pos;
    bit   done;
    exp_a = '{0, 1, 26, 27, 2, 3, 28, 29};
    rd_cnt = 0;
    prev_en = 1'b0;
    prev_pos = 2'd0;
    done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.conv_valid = 1'b1;
    bus.pool_ready = 1'b1;
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (prev_en && rd_cnt <= 8) begin
        total++;
        if (bus.rd_pos !== prev_pos) begin
          $display("[TB] FAIL first_win_rd_pos: got %0d required %0d", bus.rd_pos, prev_pos);
        end else passed++;
      end
      if (bus.buf_rd_en) begin
        if (rd_cnt < 8) begin
          total++;
          if (bus.buf_rd_addr !== 7'(exp_a[rd_cnt])) begin
            $display("[TB] FAIL first_win_addr[%0d]: got %0d required %0d",
                     rd_cnt, bus.buf_rd_addr, exp_a[rd_cnt]);
          end else passed++;
        end
        if (rd_cnt == 52) begin
          total++;
          if (bus.buf_rd_addr !== 7'd52) begin
            $display("[TB] FAIL half1_first_addr: got %0d required 52", bus.buf_rd_addr);
          end else passed++;
          done = 1;
        end
        prev_pos = 2'(rd_cnt % 4);
        rd_cnt++;
      end
      prev_en = bus.buf_rd_en;
    end
    total++;
    if (!done) begin
      $display("[TB] FAIL first_win_timeout: got %0d reads required 53", rd_cnt);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Whole frame. mode 0: steady flow, mode 1: pool_ready toggling,
  // mode 2: steady flow with stray starts while busy and at frame_done.
  task automatic test_full_frame(input int mode, input string name);
    int   wr_cnt;
    int   rd_cnt;
    int   vld_cnt;
    int   wl_cnt;
    int   fd_cnt;
    logic prev_en;
    logic [1:0] prev_pos;
    bit   done;
    wr_cnt = 0; rd_cnt = 0; vld_cnt = 0; wl_cnt = 0; fd_cnt = 0;
    prev_en = 1'b0;
    prev_pos = 2'd0;
    done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.conv_valid = 1'b1;
    bus.pool_ready = 1'b1;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      bus.start = (mode == 2) && (cyc == 100 || cyc == 400);
      bus.pool_ready = (mode == 1) ? 1'(cyc % 2) : 1'b1;
      #1;
      total++;
      if (bus.rd_valid !== prev_en) begin
        $display("[TB] FAIL %s rd_valid_lag: got %b required %b", name, bus.rd_valid, prev_en);
      end else passed++;
      total++;
      if (bus.win_last !== (prev_en && prev_pos == 2'd3)) begin
        $display("[TB] FAIL %s win_last: got %b required %b", name, bus.win_last,
                 prev_en && prev_pos == 2'd3);
      end else passed++;
      if (prev_en) begin
        vld_cnt++;
        total++;
        if (bus.rd_pos !== prev_pos) begin
          $display("[TB] FAIL %s rd_pos: got %0d required %0d", name, bus.rd_pos, prev_pos);
        end else passed++;
      end
      if (bus.win_last) wl_cnt++;
      if (bus.buf_wr_en) begin
        total++;
        if (wr_cnt >= 676 || bus.buf_wr_addr !== 7'(wr_cnt % 104)) begin
          $display("[TB] FAIL %s wr_addr[%0d]: got %0d required %0d", name, wr_cnt,
                   bus.buf_wr_addr, wr_cnt % 104);
        end else passed++;
        wr_cnt++;
      end
      if (mode == 1 && !bus.pool_ready) begin
        total++;
        if (bus.buf_rd_en !== 1'b0) begin
          $display("[TB] FAIL %s rd_en_follows_ready: got %b required 0", name, bus.buf_rd_en);
        end else passed++;
      end
      if (bus.buf_rd_en) begin
        total++;
        if (rd_cnt >= 676 || bus.buf_rd_addr !== exp_rd_addr(rd_cnt)) begin
          $display("[TB] FAIL %s rd_addr[%0d]: got %0d required %0d", name, rd_cnt,
                   bus.buf_rd_addr, exp_rd_addr(rd_cnt));
        end else passed++;
        prev_pos = 2'(rd_cnt % 4);
        rd_cnt++;
      end
      prev_en = bus.buf_rd_en;
      if (bus.frame_done) begin
        fd_cnt++;
        done = 1;
        total++;
        if (bus.busy !== 1'b0) begin
          $display("[TB] FAIL %s busy_at_done: got %b required 0", name, bus.busy);
        end else passed++;
        if (mode == 2) bus.start = 1'b1;
      end
    end
    total++;
    if (!done) begin
      $display("[TB] FAIL %s frame_timeout: got no frame_done required 1", name);
    end else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.frame_done) fd_cnt++;
      total++;
      if (bus.busy !== 1'b0) begin
        $display("[TB] FAIL %s busy_after_done: got %b required 0", name, bus.busy);
      end else passed++;
    end
    total++;
    if (wr_cnt != 676) begin
      $display("[TB] FAIL %s write_count: got %0d required 676", name, wr_cnt);
    end else passed++;
    total++;
    if (rd_cnt != 676 || vld_cnt != 676) begin
      $display("[TB] FAIL %s read_count: got %0d/%0d required 676/676", name, rd_cnt, vld_cnt);
    end else passed++;
    total++;
    if (wl_cnt != 169) begin
      $display("[TB] FAIL %s win_last_count: got %0d required 169", name, wl_cnt);
    end else passed++;
    total++;
    if (fd_cnt != 1) begin
      $display("[TB] FAIL %s frame_done_count: got %0d required 1", name, fd_cnt);
    end else passed++;
  endtask

  // With pool_ready low the writer stops after both halves (104 writes) and
  // resumes only once the 52nd read has drained half 0.
  task automatic test_stall();
    int wr_cnt;
    int rd_cnt;
    bit resumed;
    wr_cnt = 0;
    rd_cnt = 0;
    resumed = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.conv_valid = 1'b1;
    bus.pool_ready = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.buf_wr_en) wr_cnt++;
    end
    total++;
    if (wr_cnt != 104) begin
      $display("[TB] FAIL stall_write_count: got %0d required 104", wr_cnt);
    end else passed++;
    total++;
    if ({bus.conv_ready, bus.buf_rd_en} !== 2'b00) begin
      $display("[TB] FAIL stall_ready: got conv_ready/buf_rd_en %b required 00",
               {bus.conv_ready, bus.buf_rd_en});
    end else passed++;
    for (int cyc = 0; cyc < 200 && !resumed; cyc++) begin
      @(negedge clk);
      bus.pool_ready = 1'b1;
      #1;
      if (bus.buf_wr_en) begin
        resumed = 1;
        total++;
        if (rd_cnt != 52 || bus.buf_wr_addr !== 7'd0) begin
          $display("[TB] FAIL stall_resume: got reads %0d addr %0d required reads 52 addr 0",
                   rd_cnt, bus.buf_wr_addr);
        end else passed++;
      end
      if (bus.buf_rd_en) rd_cnt++;
    end
    total++;
    if (!resumed) begin
      $display("[TB] FAIL stall_resume_timeout: got no write required resume after 52 reads");
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset at write 300 clears everything without a clock edge; the next
  // frame restarts from address 0.
  task automatic test_mid_reset();
    int wr_cnt;
    bit seen;
    wr_cnt = 0;
    seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.conv_valid = 1'b1;
    bus.pool_ready = 1'b1;
    for (int cyc = 0; cyc < 1000 && wr_cnt < 300; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.buf_wr_en) wr_cnt++;
    end
    total++;
    if ({bus.busy, bus.rd_valid} !== 2'b11) begin
      $display("[TB] FAIL mid_reset_pre: got busy/rd_valid %b required 11",
               {bus.busy, bus.rd_valid});
    end else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.conv_ready, bus.buf_wr_en, bus.buf_rd_en, bus.rd_valid,
         bus.frame_done, bus.win_last} !== 7'b0) begin
      $display("[TB] FAIL mid_reset_async: got %b required 0000000",
               {bus.busy, bus.conv_ready, bus.buf_wr_en, bus.buf_rd_en,
                bus.rd_valid, bus.frame_done, bus.win_last});
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.buf_wr_en) begin
        seen = 1;
        total++;
        if (bus.buf_wr_addr !== 7'd0) begin
          $display("[TB] FAIL restart_first_addr: got %0d required 0", bus.buf_wr_addr);
        end else passed++;
      end
    end
    total++;
    if (!seen) begin
      $display("[TB] FAIL restart_timeout: got no write required first write");
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_first_window();
    test_full_frame(0, "full_frame");
    test_full_frame(1, "pool_toggle");
    test_stall();
    test_mid_reset();
    test_full_frame(2, "start_while_busy");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
